// File: rtl/alu_n_pkg.sv
// Shared opcode constants and FSM state encoding for the sequential ALU.
package alu_n_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND   = 3'b000;
  localparam logic [OP_W-1:0] OP_OR    = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR   = 3'b010;
  localparam logic [OP_W-1:0] OP_NOT   = 3'b011;
  localparam logic [OP_W-1:0] OP_ADD   = 3'b100;
  localparam logic [OP_W-1:0] OP_SHL   = 3'b101;
  localparam logic [OP_W-1:0] OP_SHR   = 3'b110;
  localparam logic [OP_W-1:0] OP_TRUNC = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    OUT   = 2'd2
  } state_e;

  function automatic logic is_shift_op(input logic [OP_W-1:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/alu_n_logic.sv
// Combinational single-cycle ALU ops and flags; shift opcodes pass in1 through
// unchanged, which is the correct zero-distance shift result.
module alu_n_logic
  import alu_n_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             ci,
  output logic [WIDTH-1:0] result,
  output logic             co,
  output logic             zero,
  output logic             ovf
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0]     sum;
  logic [SHW-1:0]     n;
  logic [WIDTH-1:0]   keep_mask;

  always_comb begin
    sum       = {1'b0, in1} + {1'b0, in2} + {{WIDTH{1'b0}}, ci};
    n         = in2[SHW-1:0];
    // ones in bits [n-1:0]; n=0 yields an all-zero mask
    keep_mask = ~({WIDTH{1'b1}} << n);

    result = in1;
    co     = 1'b0;
    ovf    = 1'b0;
    case (op)
      OP_AND:   result = in1 & in2;
      OP_OR:    result = in1 | in2;
      OP_XOR:   result = in1 ^ in2;
      OP_NOT:   result = ~in1;
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        co     = sum[WIDTH];
        ovf    = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_TRUNC: result = in1 & keep_mask;
      default:  result = in1;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_n_seq.sv
// Sequential ALU: single-cycle ops reach OUT one cycle after accept, shifts by
// n>0 take n cycles in SHIFT; result holds in OUT until out_ready, which also admits the next op.
module alu_n_seq
  import alu_n_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             co,
  output logic             zero,
  output logic             ovf
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q;
  state_e           state_d;
  logic [SHW-1:0]   cnt_q;
  logic             dir_q;
  logic             accept;
  logic             start_shift;
  logic [SHW-1:0]   n_in;
  logic [WIDTH-1:0] sh_next;
  logic             sh_bit;

  logic [WIDTH-1:0] l_result;
  logic             l_co;
  logic             l_zero;
  logic             l_ovf;

  alu_n_logic #(.WIDTH(WIDTH)) u_logic (
    .op     (op),
    .in1    (in1),
    .in2    (in2),
    .ci     (ci),
    .result (l_result),
    .co     (l_co),
    .zero   (l_zero),
    .ovf    (l_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    accept      = 1'b0;
    start_shift = 1'b0;
    state_d     = state_q;
    n_in        = in2[SHW-1:0];

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      SHIFT: begin
        if (cnt_q == SHW'(1)) begin
          state_d = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    accept      = in_valid && in_ready;
    start_shift = accept && is_shift_op(op) && (n_in != '0);
    if (accept) begin
      state_d = start_shift ? SHIFT : OUT;
    end
  end

  // one bit per cycle, with the bit leaving the word tracked as carry-out
  always_comb begin
    sh_next = dir_q ? (result >> 1) : (result << 1);
    sh_bit  = dir_q ? result[0] : result[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      co     <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
      cnt_q  <= '0;
      dir_q  <= 1'b0;
    end else if (accept) begin
      if (start_shift) begin
        result <= in1;
        cnt_q  <= n_in;
        dir_q  <= (op == OP_SHR);
        co     <= 1'b0;
        zero   <= 1'b0;
        ovf    <= 1'b0;
      end else begin
        result <= l_result;
        co     <= l_co;
        zero   <= l_zero;
        ovf    <= l_ovf;
        cnt_q  <= '0;
      end
    end else if (state_q == SHIFT) begin
      result <= sh_next;
      co     <= sh_bit;
      zero   <= (sh_next == '0);
      cnt_q  <= cnt_q - SHW'(1);
    end
  end

endmodule
